// File: rtl/dmem_arbiter.sv
// Two-port (A/B) arbiter in front of a single-ported data memory.
// Each granted request runs IDLE -> ACCESS -> RESP, so one transaction completes every 3 cycles.
//
// state  | meaning
// IDLE   | wait for a request; pick owner and latch its command
// ACCESS | drive the memory strobe for one cycle; capture load data
// RESP   | pulse owner's ack/err; record owner for round-robin
module dmem_arbiter #(
    parameter int RR_MODE    = 1,
    parameter int ADDR_LIMIT = 4096
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_req,
    input  logic        a_we,
    input  logic [31:0] a_addr,
    input  logic [31:0] a_wdata,
    output logic        a_ack,
    output logic        a_err,
    output logic [31:0] a_rdata,
    input  logic        b_req,
    input  logic        b_we,
    input  logic [31:0] b_addr,
    input  logic [31:0] b_wdata,
    output logic        b_ack,
    output logic        b_err,
    output logic [31:0] b_rdata,
    output logic        MemWrite,
    output logic        MemRead,
    output logic [31:0] address,
    output logic [31:0] data_in,
    input  logic [31:0] read_data
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    localparam logic [31:0] ADDR_LIMIT_W = 32'(ADDR_LIMIT);

    state_t      state;
    state_t      state_nxt;

    // owner encodings: 0 = port A, 1 = port B
    logic        owner;
    logic        last_owner;
    logic        lat_we;
    logic        lat_err;

    logic        grant_any;
    logic        grant_sel;
    logic        sel_we;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        sel_err;

    always_comb begin
        grant_any = a_req | b_req;
        grant_sel = 1'b0;
        if (a_req && b_req) begin
            grant_sel = (RR_MODE != 0) ? ~last_owner : 1'b0;
        end else begin
            grant_sel = b_req;
        end
        sel_we    = grant_sel ? b_we    : a_we;
        sel_addr  = grant_sel ? b_addr  : a_addr;
        sel_wdata = grant_sel ? b_wdata : a_wdata;
        sel_err   = (sel_addr[1:0] != 2'b00) || (sel_addr >= ADDR_LIMIT_W);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        MemRead   = 1'b0;
        MemWrite  = 1'b0;
        a_ack     = 1'b0;
        b_ack     = 1'b0;
        a_err     = 1'b0;
        b_err     = 1'b0;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                state_nxt = RESP;
                MemWrite  = lat_we & ~lat_err;
                MemRead   = ~lat_we & ~lat_err;
            end
            RESP: begin
                state_nxt = IDLE;
                a_ack     = ~owner;
                b_ack     = owner;
                a_err     = ~owner & lat_err;
                b_err     = owner & lat_err;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Command latch; address/data_in keep their value until the next grant.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner      <= 1'b0;
            last_owner <= 1'b1;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            address    <= 32'd0;
            data_in    <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        owner   <= grant_sel;
                        lat_we  <= sel_we;
                        lat_err <= sel_err;
                        address <= sel_addr;
                        data_in <= sel_wdata;
                    end
                end
                RESP: begin
                    last_owner <= owner;
                end
                default: begin
                end
            endcase
        end
    end

    // Load data is held per port until that port's next successful load.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_rdata <= 32'd0;
            b_rdata <= 32'd0;
        end else if (state == ACCESS && !lat_we && !lat_err) begin
            if (owner) begin
                b_rdata <= read_data;
            end else begin
                a_rdata <= read_data;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed requests push expected responses,
// a negedge monitor pops and compares them whenever an ack appears.
`timescale 1ns/1ps
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        a_req, a_we, b_req, b_we;
    logic [31:0] a_addr, a_wdata, b_addr, b_wdata;
    logic        a_ack, a_err, b_ack, b_err;
    logic [31:0] a_rdata, b_rdata;
    logic        MemWrite, MemRead;
    logic [31:0] address, data_in, read_data;

    logic [31:0] mem [0:1023] = '{default: 32'h0};

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic [31:0] last_waddr = 32'h0;
    logic [31:0] last_wdata = 32'h0;

    logic [32:0] exp_a[$];
    logic [32:0] exp_b[$];
    int          ack_port[$];
    int          ack_cyc[$];

    dmem_arbiter #(.RR_MODE(1), .ADDR_LIMIT(4096)) dut (
        .clk       (clk),
        .reset     (reset),
        .a_req     (a_req),
        .a_we      (a_we),
        .a_addr    (a_addr),
        .a_wdata   (a_wdata),
        .a_ack     (a_ack),
        .a_err     (a_err),
        .a_rdata   (a_rdata),
        .b_req     (b_req),
        .b_we      (b_we),
        .b_addr    (b_addr),
        .b_wdata   (b_wdata),
        .b_ack     (b_ack),
        .b_err     (b_err),
        .b_rdata   (b_rdata),
        .MemWrite  (MemWrite),
        .MemRead   (MemRead),
        .address   (address),
        .data_in   (data_in),
        .read_data (read_data)
    );

    always #5 clk = ~clk;

    assign read_data = mem[address[11:2]];

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            mem[0]    <= 32'd10;
            mem[1023] <= 32'h1234_5678;
        end else if (MemWrite) begin
            mem[address[11:2]] <= data_in;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [32:0] e;
        if (!reset) begin
            if (MemRead) rd_cnt++;
            if (MemWrite) begin
                wr_cnt++;
                last_waddr = address;
                last_wdata = data_in;
            end
            if (MemRead || MemWrite) check("strobe_exclusive", {31'd0, MemRead & MemWrite}, 32'd0);
            if (a_ack || b_ack) check("ack_exclusive", {31'd0, a_ack & b_ack}, 32'd0);
            if (a_ack) begin
                ack_port.push_back(0);
                ack_cyc.push_back(cyc);
                check("a_ack_expected", 32'(exp_a.size() != 0), 32'd1);
                if (exp_a.size() != 0) begin
                    e = exp_a.pop_front();
                    check("a_err", {31'd0, a_err}, {31'd0, e[32]});
                    check("a_rdata", a_rdata, e[31:0]);
                end
            end
            if (b_ack) begin
                ack_port.push_back(1);
                ack_cyc.push_back(cyc);
                check("b_ack_expected", 32'(exp_b.size() != 0), 32'd1);
                if (exp_b.size() != 0) begin
                    e = exp_b.pop_front();
                    check("b_err", {31'd0, b_err}, {31'd0, e[32]});
                    check("b_rdata", b_rdata, e[31:0]);
                end
            end
        end
    end

    // Issue one request on a port (called just after a posedge) and wait for its ack.
    task automatic run_req(input bit port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                           input int exp_rd, input int exp_wr, input string tag);
        int rd0, wr0, start, lat;
        bit seen;
        if (port == 1'b0) begin
            exp_a.push_back({err, rdata});
            a_we = we; a_addr = addr; a_wdata = wdata; a_req = 1'b1;
        end else begin
            exp_b.push_back({err, rdata});
            b_we = we; b_addr = addr; b_wdata = wdata; b_req = 1'b1;
        end
        rd0 = rd_cnt; wr0 = wr_cnt; start = cyc; seen = 1'b0; lat = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if ((port == 1'b0) ? a_ack : b_ack) begin
                seen = 1'b1;
                lat  = cyc - start;
            end
        end
        check({tag, "_ack_seen"}, {31'd0, seen}, 32'd1);
        if (seen) check({tag, "_latency"}, 32'(lat), 32'd2);
        @(posedge clk); #1;
        if (port == 1'b0) a_req = 1'b0; else b_req = 1'b0;
        check({tag, "_memread_cycles"}, 32'(rd_cnt - rd0), 32'(exp_rd));
        check({tag, "_memwrite_cycles"}, 32'(wr_cnt - wr0), 32'(exp_wr));
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_acks"}, {30'd0, a_ack, b_ack}, 32'd0);
        check({tag, "_errs"}, {30'd0, a_err, b_err}, 32'd0);
        check({tag, "_strobes"}, {30'd0, MemRead, MemWrite}, 32'd0);
        check({tag, "_address"}, address, 32'd0);
        check({tag, "_data_in"}, data_in, 32'd0);
        check({tag, "_a_rdata"}, a_rdata, 32'd0);
        check({tag, "_b_rdata"}, b_rdata, 32'd0);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        reset = 1'b1;
        a_req = 1'b0; a_we = 1'b0; a_addr = 32'h0; a_wdata = 32'h0;
        b_req = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;

        // single A load of word 0
        run_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'd10, 1, 0, "a_load0");

        // B store then A load of the same word
        run_req(1'b1, 1'b1, 32'h8, 32'hDEAD_BEEF, 1'b0, 32'h0, 0, 1, "b_store8");
        check("store_data_in", last_wdata, 32'hDEAD_BEEF);
        check("store_address", last_waddr, 32'h8);
        run_req(1'b0, 1'b0, 32'h8, 32'h0, 1'b0, 32'hDEAD_BEEF, 1, 0, "a_load8");

        // highest legal word, also leaves B as last owner
        run_req(1'b1, 1'b0, 32'hFFC, 32'h0, 1'b0, 32'h1234_5678, 1, 0, "b_load_top");

        // contention: both held for four transactions
        exp_a.push_back({1'b0, 32'd10});
        exp_a.push_back({1'b0, 32'd10});
        exp_b.push_back({1'b0, 32'hDEAD_BEEF});
        exp_b.push_back({1'b0, 32'hDEAD_BEEF});
        ack_port.delete();
        ack_cyc.delete();
        a_we = 1'b0; a_addr = 32'h0;
        b_we = 1'b0; b_addr = 32'h8;
        a_req = 1'b1; b_req = 1'b1;
        n = 0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            @(negedge clk);
            if (a_ack || b_ack) n++;
        end
        @(posedge clk); #1;
        a_req = 1'b0; b_req = 1'b0;
        check("rr_ack_count", 32'(ack_port.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            if (i < ack_port.size()) check("rr_order", 32'(ack_port[i]), 32'(i % 2));
            if (i > 0 && i < ack_cyc.size()) check("rr_spacing", 32'(ack_cyc[i] - ack_cyc[i-1]), 32'd3);
        end

        // error paths keep a_rdata and never strobe memory
        run_req(1'b0, 1'b0, 32'h6, 32'h0, 1'b1, 32'd10, 0, 0, "err_misaligned");
        run_req(1'b0, 1'b1, 32'h1000, 32'hAAAA_AAAA, 1'b1, 32'd10, 0, 0, "err_range");
        check("err_rdata_held", a_rdata, 32'd10);
        check("err_mem0_intact", mem[0], 32'd10);

        // reset in the ACCESS cycle of a store
        a_we = 1'b1; a_addr = 32'h10; a_wdata = 32'h55; a_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("mid_store_memwrite", {31'd0, MemWrite}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check_all_zero("mid_reset");
        a_req = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (a_ack || b_ack) n++;
        end
        check("no_ack_after_abort", 32'(n), 32'd0);
        check("aborted_store_not_written", mem[4], 32'd0);
        @(posedge clk); #1;
        run_req(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'd10, 1, 0, "a_after_reset");

        check("exp_a_drained", 32'(exp_a.size()), 32'd0);
        check("exp_b_drained", 32'(exp_b.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
